// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes,
// opcodes, ALU function codes and opcode classification helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_DEC   = 4'd1,
        S_EX    = 4'd2,
        S_AWB   = 4'd3,
        S_MADDR = 4'd4,
        S_MWR   = 4'd5,
        S_MRD   = 4'd6,
        S_LWB   = 4'd7,
        S_BR    = 4'd8,
        S_TRAP  = 4'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;

    // State following DEC for a non-nop instruction.
    function automatic state_e dec_next(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LI, OP_LUI,
            OP_ADDI, OP_ANDI, OP_ORI:    return S_EX;
            OP_LB, OP_SB, OP_LW, OP_SW:  return S_MADDR;
            OP_B, OP_BEQ, OP_BNE:        return S_BR;
            default:                     return S_TRAP;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LW);
    endfunction

    function automatic logic is_byte(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Wait-cycle counter shared by fetch and data-memory handshakes;
// expired marks the WAIT_MAX-th consecutive waiting cycle.
module ctrl_wait_cnt #(
    parameter int WAIT_MAX   = 15,
    parameter int WAIT_CNT_W = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == WAIT_CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle datapath control FSM with fetch/memory handshakes and trap.
// Define PERF_CNT_EN to add the Retired instruction counter output.
module multicycle_ctrl_v2
    import ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int ALU_FUNC_W = 4,
    parameter int WAIT_MAX   = 15,
    parameter int WAIT_CNT_W = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [INSTR_W-1:0]    Instr,
    input  logic                  Instr_Valid,
    input  logic                  Zero,
    input  logic                  Mem_Ready,
    output logic                  PC_Sel,
    output logic                  PC_LdEn,
    output logic                  PC_Reset,
    output logic                  RF_B_Sel,
    output logic                  RF_WrData_Sel,
    output logic                  RF_WrEn,
    output logic                  ALU_Bin_Sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  MEM_WrEn,
    output logic                  MEM_RdEn,
    output logic                  MEM_ByteOp,
    output logic                  Illegal,
    output logic                  Timeout,
    output logic [3:0]            State
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]           Retired
`endif
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 pc_reset_q;
    logic                 waiting, wait_clr, wait_exp, timeout;
    logic [5:0]           op;
    logic [3:0]           fn;
    logic [3:0]           alu;

    assign op = ir_q[INSTR_W-1 -: 6];
    assign fn = ir_q[3:0];

    ctrl_wait_cnt #(
        .WAIT_MAX   (WAIT_MAX),
        .WAIT_CNT_W (WAIT_CNT_W)
    ) u_wait (
        .clk     (Clk),
        .clr     (wait_clr),
        .en      (waiting),
        .expired (wait_exp)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        waiting = 1'b0;
        case (state_q)
            S_IF: begin
                if (Instr_Valid) begin
                    ir_d    = Instr;
                    state_d = S_DEC;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DEC:   state_d = (ir_q == '0) ? S_IF : dec_next(op);
            S_EX:    state_d = S_AWB;
            S_MADDR: state_d = is_load(op) ? S_MRD : S_MWR;
            S_MWR, S_MRD: begin
                if (Mem_Ready) begin
                    state_d = (state_q == S_MRD) ? S_LWB : S_IF;
                end else begin
                    waiting = 1'b1;
                    if (wait_exp) state_d = S_IF;
                end
            end
            default: state_d = S_IF;
        endcase
        if (Reset) begin
            state_d = S_IF;
            ir_d    = '0;
        end
        timeout  = waiting & wait_exp & ~Reset;
        wait_clr = Reset | ~waiting | wait_exp;
    end

    always_ff @(posedge Clk) begin
        state_q    <= state_d;
        ir_q       <= ir_d;
        pc_reset_q <= Reset;
    end

    always_comb begin
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        RF_B_Sel      = 1'b0;
        RF_WrData_Sel = 1'b0;
        RF_WrEn       = 1'b0;
        ALU_Bin_Sel   = 1'b0;
        alu           = ALU_ADD;
        MEM_WrEn      = 1'b0;
        MEM_RdEn      = 1'b0;
        MEM_ByteOp    = 1'b0;
        Illegal       = 1'b0;
        case (state_q)
            S_DEC: begin
                RF_B_Sel = (op != OP_RTYPE);
                if (ir_q == '0) PC_LdEn = 1'b1;
                else if (dec_next(op) == S_BR) alu = ALU_SUB;
            end
            S_EX: begin
                ALU_Bin_Sel = (op != OP_RTYPE);
                if (op == OP_RTYPE) alu = fn;
                else if (op != OP_LI && op != OP_LUI) alu = op[3:0];
            end
            S_AWB: begin
                RF_WrEn       = 1'b1;
                RF_WrData_Sel = 1'b1;
                PC_LdEn       = 1'b1;
            end
            S_MWR: begin
                MEM_WrEn = ~timeout;
                PC_LdEn  = Mem_Ready | timeout;
            end
            S_MRD: begin
                MEM_RdEn = ~timeout;
                PC_LdEn  = timeout;
            end
            S_LWB: begin
                RF_WrEn = 1'b1;
                PC_LdEn = 1'b1;
            end
            S_BR: begin
                PC_LdEn = 1'b1;
                PC_Sel  = (op == OP_B) | ((op == OP_BEQ) & Zero)
                        | ((op == OP_BNE) & ~Zero);
            end
            S_TRAP: begin
                Illegal = 1'b1;
                PC_LdEn = 1'b1;
            end
            default: ;
        endcase
        // Address setup is held steady for the whole memory access.
        if (state_q inside {S_MADDR, S_MWR, S_MRD, S_LWB}) begin
            ALU_Bin_Sel = 1'b1;
            MEM_ByteOp  = is_byte(op);
        end
    end

    assign ALU_func = ALU_FUNC_W'(alu);
    assign Timeout  = timeout;
    assign PC_Reset = pc_reset_q;
    assign State    = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (PC_LdEn && state_q != S_TRAP && !timeout) begin
            retired_d = retired_q + 32'd1;
        end
        if (Reset) retired_d = '0;
    end

    always_ff @(posedge Clk) begin
        retired_q <= retired_d;
    end

    assign Retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: directed vector table, reset/abort
// sequences and a random instruction mix against a per-instruction model.
module tb_multicycle_ctrl_v2;

    localparam int WMAX = 15;

    logic        Clk = 1'b0;
    logic        Reset, Instr_Valid, Zero, Mem_Ready;
    logic [31:0] Instr;
    logic        PC_Sel, PC_LdEn, PC_Reset, RF_B_Sel, RF_WrData_Sel;
    logic        RF_WrEn, ALU_Bin_Sel, MEM_WrEn, MEM_RdEn, MEM_ByteOp;
    logic        Illegal, Timeout;
    logic [3:0]  ALU_func, State;
`ifdef PERF_CNT_EN
    logic [31:0] Retired;
`endif

    multicycle_ctrl_v2 dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .Instr_Valid   (Instr_Valid),
        .Zero          (Zero),
        .Mem_Ready     (Mem_Ready),
        .PC_Sel        (PC_Sel),
        .PC_LdEn       (PC_LdEn),
        .PC_Reset      (PC_Reset),
        .RF_B_Sel      (RF_B_Sel),
        .RF_WrData_Sel (RF_WrData_Sel),
        .RF_WrEn       (RF_WrEn),
        .ALU_Bin_Sel   (ALU_Bin_Sel),
        .ALU_func      (ALU_func),
        .MEM_WrEn      (MEM_WrEn),
        .MEM_RdEn      (MEM_RdEn),
        .MEM_ByteOp    (MEM_ByteOp),
        .Illegal       (Illegal),
        .Timeout       (Timeout),
        .State         (State)
`ifdef PERF_CNT_EN
        ,
        .Retired       (Retired)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] st;
        logic prst, psel, pld, bsel, wds, rfw, bin;
        logic [3:0] alu;
        logic mw, mr, by, ill, to;
    } e_t;

    typedef struct {
        logic v; logic [31:0] i; logic r; logic z; e_t e;
    } cyc_t;

    typedef struct {
        string nm; logic [31:0] ins; int vd; int rd; logic z; int len;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   if_idle = 0;
    int   ret_cnt = 0;
    cyc_t q[$];
    vec_t tbl[$];
    logic [5:0] ops [13] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000,
                             6'b110010, 6'b110011, 6'b000011, 6'b000111,
                             6'b001111, 6'b011111, 6'b111111, 6'b000000,
                             6'b000001};

    function automatic logic rb();
        return logic'($urandom % 2);
    endfunction

    function automatic logic [19:0] act();
        return {State, PC_Reset, PC_Sel, PC_LdEn, RF_B_Sel, RF_WrData_Sel,
                RF_WrEn, ALU_Bin_Sel, ALU_func, MEM_WrEn, MEM_RdEn,
                MEM_ByteOp, Illegal, Timeout};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] i, input logic r,
                        input logic z, input e_t e);
        cyc_t c;
        c.v = v; c.i = i; c.r = r; c.z = z; c.e = e;
        q.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, from the ISA rules.
    task automatic build(input logic [31:0] ins, input int vd, input int rd,
                         input logic zb);
        logic [5:0] op;
        e_t e;
        bit alu_c, mem_c, br_c, ld, by, tmo;
        op    = ins[31:26];
        alu_c = op inside {6'b100000, 6'b111000, 6'b111001,
                           6'b110000, 6'b110010, 6'b110011};
        mem_c = op inside {6'b000011, 6'b000111, 6'b001111, 6'b011111};
        br_c  = op inside {6'b111111, 6'b000000, 6'b000001};
        ld    = op inside {6'b000011, 6'b001111};
        by    = op inside {6'b000011, 6'b000111};
        for (int k = 0; k < vd; k++) begin
            e = '0;
            if_idle++;
            if (if_idle == WMAX) begin
                e.to = 1'b1;
                if_idle = 0;
            end
            push(1'b0, $urandom, rb(), rb(), e);
        end
        e = '0;
        push(1'b1, ins, rb(), rb(), e);
        if_idle = 0;
        e = '0; e.st = 4'd1; e.bsel = (op != 6'b100000);
        if (ins == 32'd0) begin
            e.pld = 1'b1;
            push(rb(), $urandom, rb(), rb(), e);
            return;
        end
        if (br_c) e.alu = 4'b0001;
        push(rb(), $urandom, rb(), rb(), e);
        if (alu_c) begin
            e = '0; e.st = 4'd2;
            if (op == 6'b100000) begin
                e.alu = ins[3:0];
            end else begin
                e.bin = 1'b1;
                e.alu = (op inside {6'b111000, 6'b111001}) ? 4'd0 : op[3:0];
            end
            push(rb(), $urandom, rb(), rb(), e);
            e = '0; e.st = 4'd3; e.rfw = 1'b1; e.wds = 1'b1; e.pld = 1'b1;
            push(rb(), $urandom, rb(), rb(), e);
        end else if (mem_c) begin
            e = '0; e.st = 4'd4; e.bin = 1'b1; e.by = by;
            push(rb(), $urandom, rb(), rb(), e);
            tmo = 1'b0;
            for (int k = 0; k < WMAX; k++) begin
                e = '0; e.st = ld ? 4'd6 : 4'd5; e.bin = 1'b1; e.by = by;
                if (k == rd) begin
                    if (ld) e.mr = 1'b1;
                    else begin e.mw = 1'b1; e.pld = 1'b1; end
                    push(rb(), $urandom, 1'b1, rb(), e);
                    break;
                end
                if (k == WMAX - 1) begin
                    e.to = 1'b1; e.pld = 1'b1; tmo = 1'b1;
                    push(rb(), $urandom, 1'b0, rb(), e);
                    break;
                end
                if (ld) e.mr = 1'b1;
                else e.mw = 1'b1;
                push(rb(), $urandom, 1'b0, rb(), e);
            end
            if (ld && !tmo) begin
                e = '0; e.st = 4'd7; e.rfw = 1'b1; e.pld = 1'b1;
                e.bin = 1'b1; e.by = by;
                push(rb(), $urandom, rb(), rb(), e);
            end
        end else if (br_c) begin
            e = '0; e.st = 4'd8; e.pld = 1'b1;
            e.psel = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? zb : ~zb;
            push(rb(), $urandom, rb(), zb, e);
        end else begin
            e = '0; e.st = 4'd9; e.ill = 1'b1; e.pld = 1'b1;
            push(rb(), $urandom, rb(), rb(), e);
        end
    endtask

    task automatic apply(input string nm, input int lim, input int exp_len);
        cyc_t c;
        int   n = 0;
        int   len = -1;
        bit   moved = 1'b0;
        while (q.size() > 0 && n < lim) begin
            c = q.pop_front();
            Instr = c.i; Instr_Valid = c.v; Mem_Ready = c.r; Zero = c.z;
            @(negedge Clk);
            chk(nm, 32'(act()), 32'(c.e));
            if (c.e.pld && c.e.st != 4'd9 && !c.e.to) ret_cnt++;
            @(posedge Clk);
            #1;
            n++;
            if (State != 4'd0) moved = 1'b1;
            else if (moved && len < 0) len = n;
        end
        q.delete();
        if (exp_len > 0) chk({nm, "_len"}, 32'(len), 32'(exp_len));
    endtask

    task automatic do_reset(input int n);
        e_t r;
        r = '0; r.prst = 1'b1;
        Reset = 1'b1; Instr_Valid = 1'b0; Mem_Ready = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("reset", 32'(act()), 32'(r));
        end
        Reset = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_release", 32'(act()), 32'h0);
        @(posedge Clk);
        #1;
        if_idle = 2;
        ret_cnt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Instr = '0; Instr_Valid = 1'b0;
        Zero = 1'b0; Mem_Ready = 1'b0;
        do_reset(2);

        tbl.push_back('{"add",     32'h8000_0000, 0,  0, 1'b0, 4});
        tbl.push_back('{"sub",     32'h8000_0001, 0,  0, 1'b0, 4});
        tbl.push_back('{"addi",    32'hC000_1234, 0,  0, 1'b0, 4});
        tbl.push_back('{"andi",    32'hC800_0000, 0,  0, 1'b0, 4});
        tbl.push_back('{"ori",     32'hCC00_0000, 0,  0, 1'b0, 4});
        tbl.push_back('{"li",      32'hE000_0005, 0,  0, 1'b0, 4});
        tbl.push_back('{"lui",     32'hE400_0000, 0,  0, 1'b0, 4});
        tbl.push_back('{"lw_d3",   32'h3C00_0010, 0,  2, 1'b0, 7});
        tbl.push_back('{"lw",      32'h3C00_0010, 0,  0, 1'b0, 5});
        tbl.push_back('{"lb",      32'h0C00_0000, 0,  1, 1'b0, 6});
        tbl.push_back('{"sb",      32'h1C00_0000, 0,  0, 1'b0, 4});
        tbl.push_back('{"sw",      32'h7C00_0000, 0,  3, 1'b0, 7});
        tbl.push_back('{"sw_edge", 32'h7C00_0000, 0, 14, 1'b0, 18});
        tbl.push_back('{"sw_tmo",  32'h7C00_0000, 0, 20, 1'b0, 18});
        tbl.push_back('{"lw_tmo",  32'h3C00_0000, 0, 20, 1'b0, 18});
        tbl.push_back('{"beq_t",   32'h0000_0004, 0,  0, 1'b1, 3});
        tbl.push_back('{"beq_nt",  32'h0000_0004, 0,  0, 1'b0, 3});
        tbl.push_back('{"bne_t",   32'h0400_0008, 0,  0, 1'b0, 3});
        tbl.push_back('{"bne_nt",  32'h0400_0008, 0,  0, 1'b1, 3});
        tbl.push_back('{"b",       32'hFC00_0000, 0,  0, 1'b0, 3});
        tbl.push_back('{"trap",    32'hA800_0000, 0,  0, 1'b0, 3});
        tbl.push_back('{"nop",     32'h0000_0000, 0,  0, 1'b0, 2});
        tbl.push_back('{"fetch_w", 32'h8000_0002, 2,  0, 1'b0, 6});
        tbl.push_back('{"if_tmo",  32'h0000_0000, 16, 0, 1'b0, 18});

        foreach (tbl[k]) begin
            build(tbl[k].ins, tbl[k].vd, tbl[k].rd, tbl[k].z);
            apply(tbl[k].nm, 1000, tbl[k].len);
        end

        build(32'h3C00_0010, 0, 20, 1'b0);
        apply("lw_abort", 5, -1);
        do_reset(1);
        build(32'h8000_0003, 0, 0, 1'b0);
        apply("post_abort", 100, 4);

        for (int k = 0; k < 80; k++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            int          rd;
            op  = ($urandom % 4 == 0) ? 6'($urandom) : ops[$urandom % 13];
            ins = {op, 26'($urandom)};
            rd  = ($urandom % 8 == 0) ? int'($urandom_range(13, 16))
                                      : int'($urandom_range(0, 4));
            build(ins, int'($urandom_range(0, 3)), rd, rb());
            apply("rand", 1000, -1);
        end

`ifdef PERF_CNT_EN
        @(negedge Clk);
        chk("retired", Retired, 32'(ret_cnt));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
